fetch_queue_stage: RTL and testbench
====================================

# fetch_queue_stage

Parametrised successor to the single-register fetch stage. It holds a free-running fetch PC and reads one instruction word per cycle from a combinational-read instruction memory. Fetched words go into a DEPTH-entry prefetch queue, and the decode stage drains that queue over a valid/ready handshake. Decode stalls therefore no longer freeze fetch immediately, and a redirect (branch, call, return, interrupt vector) flushes the queue in one cycle.

## Interface
Parameters:
- INSTR_W, 16: instruction word width.
- PC_W, 32: PC and address width.
- RESET_PC, 32: fetch PC loaded on reset (first instruction-memory address).
- DEPTH, 4: queue entries; power of two, ≥ 2.
- NOP, 0: INSTR_W-bit encoding driven while clear_instruction is high.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-low; sampled on the rising edge of clk.
- redirect, in, 1: load redirect_pc into the fetch PC and flush the queue.
- redirect_pc, in, PC_W: new fetch address.
- clear_instruction, in, 1: force the instruction output to NOP.
- imem_addr, out, PC_W: instruction memory address; equals the fetch PC.
- imem_rdata, in, INSTR_W: word at imem_addr, valid in the same cycle.
- out_valid, out, 1: queue head is valid.
- out_ready, in, 1: decode accepts the head this cycle.
- instruction_r, out, INSTR_W: head instruction, or NOP while clear_instruction is high.
- pc_plus_one_r, out, PC_W: address of the head instruction + 1.
- stall_cycles, out, 32: present only with FETCH_PERF_CNT_EN.

## Operation
- State:
  - fetch_pc (PC_W)
  - DEPTH entries of {instr, pc_plus_one}
  - wr_ptr and rd_ptr, each log2(DEPTH) bits
  - count, log2(DEPTH)+1 bits
- pop = out_valid & out_ready.
- push = !redirect & (count < DEPTH | pop).
- On push:
  - entry[wr_ptr] ← {imem_rdata, fetch_pc+1}.
  - wr_ptr increments and wraps modulo DEPTH.
  - fetch_pc ← fetch_pc+1, wrapping modulo 2^PC_W.
- On pop: rd_ptr increments and wraps.
- count update: count ← count + push − pop.
- Full queue with pop in the same cycle: push is permitted and count stays at DEPTH.
- Full queue without pop: the fetch PC holds and imem_addr is stable.
- Empty queue: out_valid = 0 and pop is impossible. A push in that cycle becomes visible on the next cycle, with no bypass.
- Redirect, which has priority over push and pop:
  - count ← 0, wr_ptr ← 0, rd_ptr ← 0.
  - fetch_pc ← redirect_pc.
  - The word at the old PC is discarded.
  - A handshake occurring in the same cycle is still treated as consumed by decode, but the queue is emptied anyway.
- clear_instruction is purely combinational on the output: instruction_r = NOP while it is high.
  - It does not change pc_plus_one_r, out_valid, or any queue state.
  - The entry is consumed only by a handshake.
- With out_valid = 0, instruction_r and pc_plus_one_r hold the stale head contents; decode ignores them.

## Timing
- Reset (reset = 0 at an edge) sets:
  - fetch_pc = RESET_PC, count = 0, wr_ptr = 0, rd_ptr = 0.
  - out_valid = 0, instruction_r = 0, pc_plus_one_r = 0.
  - All queue entries = 0, and stall_cycles = 0.
- Reset asserted mid-operation discards all entries and overrides redirect, push and pop in that cycle.
- Latency:
  - The first edge after reset release pushes mem[RESET_PC]; out_valid = 1 in the following cycle.
  - After a redirect edge, the next edge pushes mem[redirect_pc]; out_valid = 1 one cycle later.
  - Redirect-to-valid latency is 2 cycles.
- Throughput: one instruction per cycle sustained when out_ready is held at 1.
- Hold rule: out_valid never deasserts without a pop, redirect or reset, and the head stays stable while out_valid & !out_ready.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds the stall_cycles output port.
  - stall_cycles increments on each edge where count == DEPTH, !pop, !redirect and reset is high.
  - It saturates at 2^32−1 and clears on reset.
- FETCH_PERF_CNT_EN undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Reset release with RESET_PC=32, mem[32..35]=A,B,C,D and out_ready=1:
  - out_valid rises 2 edges after release.
  - instruction_r reads A,B,C,D on consecutive cycles, with pc_plus_one_r = 33,34,35,36.
- Backpressure: hold out_ready=0 for 8 cycles with DEPTH=4.
  - count saturates at 4 and imem_addr stays at 36.
  - Head remains A/33; stall_cycles = 4 (macro on).
  - Releasing out_ready drains A..D, then E follows with no gap.
- Redirect with 3 entries queued: redirect=1, redirect_pc=0x100, mem[0x100]=X.
  - Next cycle: out_valid=0 and imem_addr=0x100.
  - The cycle after: out_valid=1, instruction_r=X, pc_plus_one_r=0x101.
- clear_instruction=1 while out_valid=1 and out_ready=0:
  - instruction_r = NOP and pc_plus_one_r is unchanged.
  - Deasserting clear_instruction restores the original head word.
- Wrap, with PC_W=8 and redirect_pc=0xFE: fetched pc_plus_one_r sequence is 0xFF, 0x00, 0x01.
- Reset mid-stream, with reset low in the same cycle as a push and a pop:
  - Next cycle: out_valid=0 and imem_addr=RESET_PC.
  - stall_cycles=0.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: free-running fetch PC feeding a DEPTH-entry prefetch
// queue that decode drains over a valid/ready handshake. A redirect reloads
// the fetch PC and flushes the queue in one cycle.
// Optional feature macro: FETCH_PERF_CNT_EN adds the stall_cycles counter
// (edges spent with a full queue that decode did not drain).
module fetch_queue_stage #(
    parameter int                  INSTR_W  = 16,
    parameter int                  PC_W     = 32,
    parameter logic [PC_W-1:0]     RESET_PC = PC_W'(32),
    parameter int                  DEPTH    = 4,
    parameter logic [INSTR_W-1:0]  NOP      = INSTR_W'(0)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                clear_instruction,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  instruction_r,
    output logic [PC_W-1:0]     pc_plus_one_r
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    fetch_pc_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [INSTR_W-1:0] instr_mem_r [DEPTH];
    logic [PC_W-1:0]    pcp1_mem_r  [DEPTH];

    logic               pop_s;
    logic               push_s;
    logic               full_s;
    logic [PC_W-1:0]    pc_inc_s;
    logic [CNT_W-1:0]   count_next_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign pc_inc_s  = fetch_pc_r + PC_W'(1);
    assign out_valid = (count_r != {CNT_W{1'b0}});
    assign pop_s     = out_valid & out_ready;
    // A full queue may still accept a word when the head leaves this cycle.
    assign push_s    = ~redirect & (~full_s | pop_s);
    assign imem_addr = fetch_pc_r;

    // Head of queue; clear_instruction only masks the word, never the entry.
    assign instruction_r = clear_instruction ? NOP : instr_mem_r[rd_ptr_r];
    assign pc_plus_one_r = pcp1_mem_r[rd_ptr_r];

    // Occupancy after this edge's push/pop (redirect handled in the register).
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Fetch PC, queue pointers and occupancy; reset beats redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_r <= RESET_PC;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_r <= pc_inc_s;
                wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Queue storage: each entry holds the fetched word and its successor PC.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                instr_mem_r[i] <= {INSTR_W{1'b0}};
                pcp1_mem_r[i]  <= {PC_W{1'b0}};
            end else if (push_s && (wr_ptr_r == PTR_W'(i))) begin
                instr_mem_r[i] <= imem_rdata;
                pcp1_mem_r[i]  <= pc_inc_s;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    assign stall_cycles = stall_cnt_r;

    // Count edges where fetch is blocked by a full, undrained queue; saturating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
        end else if (full_s && !pop_s && !redirect && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: a queue-level model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
// Instruction memory content: mem[a] = a[15:0] ^ 16'hC3A5.
module tb_fetch_queue_stage;

    localparam int               INSTR_W  = 16;
    localparam int               PC_W     = 32;
    localparam int               DEPTH    = 4;
    localparam logic [31:0]      RESET_PC = 32'd32;
    localparam logic [15:0]      NOP      = 16'h5A5A;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = 32'd0;
    logic               clear_instruction = 1'b0;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [INSTR_W-1:0] instruction_r;
    logic [PC_W-1:0]    pc_plus_one_r;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mem_f(input logic [31:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    assign imem_rdata = mem_f(imem_addr);

    fetch_queue_stage #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH),
        .NOP     (NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .clear_instruction(clear_instruction),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .instruction_r    (instruction_r),
        .pc_plus_one_r    (pc_plus_one_r)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Model state: queue of {instr, pc_plus_one}, fetch PC, stall count.
    logic [INSTR_W+PC_W-1:0] mq[$];
    logic [PC_W-1:0]         m_pc;
    logic [31:0]             m_stall;
    bit                      m_known = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit popm;
        if (!reset) begin
            mq.delete();
            m_pc    = RESET_PC;
            m_stall = 32'd0;
            m_known = 1'b1;
        end else if (redirect) begin
            mq.delete();
            m_pc = redirect_pc;
        end else begin
            popm = (mq.size() != 0) && out_ready;
            if (mq.size() == DEPTH && !popm && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 32'd1;
            if (popm)
                void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back({mem_f(m_pc), m_pc + 32'd1});
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare DUT outputs against the model every cycle once reset was seen.
    always @(negedge clk) begin
        if (m_known) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("m_instruction", instruction_r,
                    clear_instruction ? NOP : mq[0][INSTR_W+PC_W-1:PC_W]);
                chk("m_pc_plus_one", pc_plus_one_r, mq[0][PC_W-1:0]);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("m_stall_cycles", stall_cycles, m_stall);
`endif
        end
    end

    logic [15:0] exp_i [4];
    logic [31:0] exp_p [4];

    initial begin
        // Reset state
        reset = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_instr", instruction_r, 16'h0000);
        chk("rst_pcp1", pc_plus_one_r, 32'd0);
        chk("rst_addr", imem_addr, 32'd32);

        // Backpressure from reset release: fills to 4 and holds
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_addr", imem_addr, 32'd36);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_instr", instruction_r, 16'hC385);
        chk("bp_pcp1", pc_plus_one_r, 32'd33);
`ifdef FETCH_PERF_CNT_EN
        chk("bp_stall", stall_cycles, 32'd4);
`endif
        out_ready = 1'b1;
        exp_i[0] = 16'hC384; exp_i[1] = 16'hC387; exp_i[2] = 16'hC386; exp_i[3] = 16'hC381;
        exp_p[0] = 32'd34;   exp_p[1] = 32'd35;   exp_p[2] = 32'd36;   exp_p[3] = 32'd37;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_instr", instruction_r, exp_i[i]);
            chk("drain_pcp1", pc_plus_one_r, exp_p[i]);
        end

        // Release with out_ready high: A,B,C,D on consecutive cycles
        reset = 1'b0; tick();
        reset = 1'b1;
        chk("rel_valid0", out_valid, 1'b0);
        exp_i[0] = 16'hC385; exp_i[1] = 16'hC384; exp_i[2] = 16'hC387; exp_i[3] = 16'hC386;
        exp_p[0] = 32'd33;   exp_p[1] = 32'd34;   exp_p[2] = 32'd35;   exp_p[3] = 32'd36;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rel_valid", out_valid, 1'b1);
            chk("rel_instr", instruction_r, exp_i[i]);
            chk("rel_pcp1", pc_plus_one_r, exp_p[i]);
        end

        // Redirect with 3 entries queued
        reset = 1'b0; tick();
        reset = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir_valid0", out_valid, 1'b0);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        chk("redir_valid1", out_valid, 1'b1);
        chk("redir_instr", instruction_r, 16'hC2A5);
        chk("redir_pcp1", pc_plus_one_r, 32'h101);

        // clear_instruction masks only the word
        clear_instruction = 1'b1; #1;
        chk("clr_instr", instruction_r, NOP);
        chk("clr_pcp1", pc_plus_one_r, 32'h101);
        chk("clr_valid", out_valid, 1'b1);
        tick(); tick();
        clear_instruction = 1'b0; #1;
        chk("clr_restore", instruction_r, 16'hC2A5);

        // PC wrap at 2^PC_W; redirect coincides with a handshake
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        chk("wrap_valid0", out_valid, 1'b0);
        exp_p[0] = 32'hFFFF_FFFF; exp_p[1] = 32'h0000_0000; exp_p[2] = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrap_pcp1", pc_plus_one_r, exp_p[i]);
        end

        // Reset mid-stream with push and pop pending
        reset = 1'b0; tick();
        chk("mid_valid", out_valid, 1'b0);
        chk("mid_addr", imem_addr, 32'd32);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_stall", stall_cycles, 32'd0);
`endif
        reset = 1'b1; tick();
        chk("mid_instr", instruction_r, 16'hC385);

        // Mixed handshake pattern, checked by the model only
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 3) != 0;
            redirect  = (i == 13);
            redirect_pc = 32'h0000_0200;
            tick();
        end
        redirect = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
